vga_scan_generator: RTL

- Produces the raster scan that drives the color mapper: pixel coordinates DrawX/DrawY, VGA sync strobes, blanking, and frame/line markers.
- Runs from the 50 MHz system Clk. An internal divider creates a pixel-rate enable (25 MHz for 640x480@60).
- Sits between the top level and the color mapper. The color mapper consumes DrawX/DrawY; the game FSM uses frame_start to update block positions once per frame.

---
 rtl/vga_scan_generator.sv | 95 +++++++++
 1 files changed

// File: rtl/vga_scan_generator.sv
// Raster scan generator: pixel-rate enable, DrawX/DrawY counters, active-low syncs,
// blanking and line/frame start pulses, all registered and coherent with the counters.
module vga_scan_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_en,
    output logic       hs,
    output logic       vs,
    output logic       blank_n,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             hs_q, vs_q, blank_n_q, line_q, frame_q;
    logic             pix, x_wrap, y_wrap;

    // Range test done in int so a window end of 1024 cannot overflow 10 bits.
    function automatic logic in_range(input logic [9:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

    always_comb begin
        pix    = (div_q == DIV_LAST);
        div_d  = pix ? '0 : div_q + 1'b1;
        x_wrap = pix && (x_q == H_LAST);
        y_wrap = x_wrap && (y_q == V_LAST);
        x_d    = x_q;
        y_d    = y_q;
        if (pix) begin
            x_d = x_wrap ? 10'd0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = y_wrap ? 10'd0 : y_q + 10'd1;
            end
        end
    end

    // Sync/blank are derived from the next counter values so they land together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q     <= '0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b1;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hs_q      <= ~in_range(x_d, HS_START, HS_END);
            vs_q      <= ~in_range(y_d, VS_START, VS_END);
            blank_n_q <= in_range(x_d, 0, H_VISIBLE) && in_range(y_d, 0, V_VISIBLE);
            line_q    <= x_wrap;
            frame_q   <= y_wrap;
        end
    end

    assign pixel_en    = pix;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank_n     = blank_n_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign DrawX       = x_q;
    assign DrawY       = y_q;

endmodule
